// File: rtl/assembler_pkg.sv
// Shared definitions for the nibble entry path and the register-file write stage.
package assembler_pkg;

  localparam int NIBBLE_W      = 4;
  localparam int DEFAULT_WIDTH = 16;

  typedef enum logic {
    COLLECT = 1'b0,
    HOLD    = 1'b1
  } asm_state_t;

endpackage

// File: rtl/rise_edge_detect.sv
// One-cycle pulse on a rising level; combinational output, one register of history.
// A level already high at reset release produces no pulse until it falls and rises.
module rise_edge_detect (
  input  logic clk,
  input  logic reset,
  input  logic level_in,
  output logic edge_out
);

  logic level_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) level_q <= 1'b0;
    else       level_q <= level_in;
  end

  assign edge_out = level_in & ~level_q;

endmodule

// File: rtl/nibble_word_assembler.sv
// Shifts one nibble per enter press into a WIDTH-bit word, then offers it with valid/ready.
// word_valid rises one cycle after the last commit and holds until wr_ready; presses while held set overrun.
module nibble_word_assembler
  import assembler_pkg::*;
#(
  parameter  int WIDTH   = DEFAULT_WIDTH,
  localparam int NIBBLES = WIDTH / NIBBLE_W,
  localparam int CNT_W   = $clog2(NIBBLES + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       nibble_in,
  input  logic             enter,
  input  logic             clear,
  input  logic             wr_ready,
  output logic [WIDTH-1:0] word_out,
  output logic             word_valid,
  output logic [CNT_W-1:0] nibble_count,
  output logic             overrun
);

  asm_state_t state;
  logic       enter_edge;

  rise_edge_detect u_enter_edge (
    .clk      (clk),
    .reset    (reset),
    .level_in (enter),
    .edge_out (enter_edge)
  );

  // clear outranks a simultaneous transfer or enter edge; the edge detector keeps tracking.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= COLLECT;
      word_out     <= '0;
      word_valid   <= 1'b0;
      nibble_count <= '0;
      overrun      <= 1'b0;
    end else if (clear) begin
      state        <= COLLECT;
      word_out     <= '0;
      word_valid   <= 1'b0;
      nibble_count <= '0;
      overrun      <= 1'b0;
    end else begin
      case (state)
        COLLECT: begin
          if (enter_edge) begin
            word_out     <= {word_out[WIDTH-NIBBLE_W-1:0], nibble_in};
            nibble_count <= nibble_count + CNT_W'(1);
            if (nibble_count == CNT_W'(NIBBLES - 1)) begin
              state      <= HOLD;
              word_valid <= 1'b1;
            end
          end
        end
        HOLD: begin
          if (enter_edge) overrun <= 1'b1;
          if (wr_ready) begin
            state        <= COLLECT;
            word_out     <= '0;
            word_valid   <= 1'b0;
            nibble_count <= '0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nibble_word_assembler.sv
// Directed bench for nibble_word_assembler (WIDTH=16) with a queue-based reference model.
module tb_nibble_word_assembler;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  nibble_in = 4'h0;
  logic        enter = 1'b0;
  logic        clear = 1'b0;
  logic        wr_ready = 1'b0;
  logic [15:0] word_out;
  logic        word_valid;
  logic [2:0]  nibble_count;
  logic        overrun;

  int errors = 0;
  int checks = 0;

  nibble_word_assembler #(.WIDTH(16)) dut (
    .clk          (clk),
    .reset        (rst),
    .nibble_in    (nibble_in),
    .enter        (enter),
    .clear        (clear),
    .wr_ready     (wr_ready),
    .word_out     (word_out),
    .word_valid   (word_valid),
    .nibble_count (nibble_count),
    .overrun      (overrun)
  );

  always #5 clk = ~clk;

  // Reference model: list of committed nibbles plus held/overrun flags.
  logic [3:0]  mq[$];
  logic        m_held = 1'b0;
  logic        m_ovr  = 1'b0;
  logic        m_prev = 1'b0;
  logic [15:0] mx[$];
  logic [15:0] dx[$];

  function automatic logic [15:0] word_of();
    int n;
    int w;
    n = mq.size();
    w = 0;
    for (int i = 0; i < n; i++) w = w + int'(mq[i]) * (16 ** (n - 1 - i));
    return 16'(w);
  endfunction

  always @(posedge clk or posedge rst) begin
    logic m_edge;
    if (rst) begin
      mq.delete();
      m_held = 1'b0;
      m_ovr  = 1'b0;
      m_prev = 1'b0;
    end else begin
      m_edge = enter && !m_prev;
      m_prev = enter;
      if (clear) begin
        mq.delete();
        m_held = 1'b0;
        m_ovr  = 1'b0;
      end else if (m_held) begin
        if (m_edge) m_ovr = 1'b1;
        if (wr_ready) begin
          mx.push_back(word_of());
          mq.delete();
          m_held = 1'b0;
        end
      end else if (m_edge) begin
        mq.push_back(nibble_in);
        if (mq.size() == 4) m_held = 1'b1;
      end
    end
  end

  // Words actually taken from the DUT at the handshake edge.
  always @(posedge clk) begin
    if (!rst && !clear && word_valid && wr_ready) dx.push_back(word_out);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison of {word_out, word_valid, overrun, nibble_count} against the model.
  always @(negedge clk) begin
    check("cycle", {11'b0, word_out, word_valid, overrun, nibble_count},
          {11'b0, word_of(), m_held, m_ovr, 3'(mq.size())});
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic press(input logic [3:0] n);
    nibble_in = n;
    enter = 1'b1;
    tick();
    enter = 1'b0;
    nibble_in = 4'($urandom);
    tick();
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #1 rst = 1'b1;
    tick();
    tick();
    check("reset_word", 32'(word_out), 32'h0);
    check("reset_flags", {29'b0, word_valid, overrun, 1'b0}, 32'h0);
    check("reset_count", 32'(nibble_count), 32'h0);
    rst = 1'b0;
    tick();

    // 1011 entered, held 10 cycles with wr_ready low
    press(4'h1); check("t1_cnt1", 32'(nibble_count), 32'd1);
    press(4'h0); check("t1_cnt2", 32'(nibble_count), 32'd2);
    press(4'h1); check("t1_cnt3", 32'(nibble_count), 32'd3);
    nibble_in = 4'h1; enter = 1'b1;
    tick();
    check("t1_valid_latency", 32'(word_valid), 32'd1);
    check("t1_cnt4", 32'(nibble_count), 32'd4);
    enter = 1'b0;
    repeat (10) tick();
    check("t1_word_held", 32'(word_out), 32'h1011);
    check("t1_valid_held", 32'(word_valid), 32'd1);
    wr_ready = 1'b1; tick(); wr_ready = 1'b0;
    check("t1_valid_drop", 32'(word_valid), 32'd0);

    // ABCD with a single ready cycle
    press(4'hA); press(4'hB); press(4'hC); press(4'hD);
    check("t2_word", 32'(word_out), 32'hABCD);
    wr_ready = 1'b1; tick(); wr_ready = 1'b0;
    check("t2_after", {8'b0, word_out, 7'b0, word_valid}, 32'h0);
    check("t2_cnt", 32'(nibble_count), 32'd0);
    check("t2_xfers", 32'(dx.size()), 32'd2);

    // held key commits once
    nibble_in = 4'h5; enter = 1'b1;
    repeat (20) tick();
    enter = 1'b0; tick();
    check("t3_cnt", 32'(nibble_count), 32'd1);
    check("t3_word", 32'(word_out), 32'h0005);
    clear = 1'b1; tick(); clear = 1'b0;

    // overrun while held, and edge coinciding with transfer
    press(4'h9); press(4'h8); press(4'h7); press(4'h6);
    press(4'hF);
    check("t4_ovr", 32'(overrun), 32'd1);
    check("t4_word", 32'(word_out), 32'h9876);
    nibble_in = 4'h2; enter = 1'b1; wr_ready = 1'b1;
    tick();
    enter = 1'b0; wr_ready = 1'b0;
    tick();
    check("t4_dropped", {13'b0, word_out, nibble_count}, 32'h0);
    check("t4_ovr_sticky", 32'(overrun), 32'd1);
    clear = 1'b1; tick(); clear = 1'b0;
    check("t4_ovr_cleared", 32'(overrun), 32'd0);

    // clear coincident with an enter edge
    press(4'h3); press(4'h7);
    check("t5_partial", 32'(word_out), 32'h0037);
    nibble_in = 4'h9; enter = 1'b1; clear = 1'b1;
    tick();
    enter = 1'b0; clear = 1'b0;
    tick();
    check("t5_cleared", {13'b0, word_out, nibble_count}, 32'h0);
    press(4'h1); press(4'h2); press(4'h3); press(4'h4);
    check("t5_word", 32'(word_out), 32'h1234);

    // clear discards a held word even with wr_ready high
    clear = 1'b1; wr_ready = 1'b1;
    tick();
    clear = 1'b0; wr_ready = 1'b0;
    check("t5b_valid", 32'(word_valid), 32'd0);
    check("t5b_no_xfer", 32'(dx.size()), 32'd3);

    // wr_ready tied high gives a one-cycle valid pulse
    wr_ready = 1'b1;
    press(4'h5); press(4'h6); press(4'h7);
    nibble_in = 4'h8; enter = 1'b1;
    tick();
    check("t6_pulse_hi", {15'b0, word_out, word_valid}, {15'b0, 16'h5678, 1'b1});
    enter = 1'b0;
    tick();
    check("t6_pulse_lo", 32'(word_valid), 32'd0);
    wr_ready = 1'b0;

    // asynchronous reset during HOLD with wr_ready high
    press(4'hC); press(4'hA); press(4'hF); press(4'hE);
    check("t7_held", {15'b0, word_out, word_valid}, {15'b0, 16'hCAFE, 1'b1});
    wr_ready = 1'b1;
    #1 rst = 1'b1;
    #1;
    check("t7_async", {12'b0, word_out, word_valid, overrun, nibble_count}, 32'h0);
    tick();
    rst = 1'b0; wr_ready = 1'b0;
    tick();

    check("xfer_count", 32'(dx.size()), 32'(mx.size()));
    check("xfer_count_lit", 32'(dx.size()), 32'd4);
    for (int i = 0; i < dx.size() && i < mx.size(); i++)
      check("xfer_word", 32'(dx[i]), 32'(mx[i]));
    if (mx.size() == 4) begin
      check("model_x0", 32'(mx[0]), 32'h1011);
      check("model_x1", 32'(mx[1]), 32'hABCD);
      check("model_x2", 32'(mx[2]), 32'h9876);
      check("model_x3", 32'(mx[3]), 32'h5678);
    end else begin
      check("model_xfers", 32'(mx.size()), 32'd4);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/nibble_word_assembler.md
Name: nibble_word_assembler

Overview:
- Downstream stage of the switch-to-nibble converter. Takes its 4-bit value and collects successive nibbles into a WIDTH-bit word.
- A rising edge on the enter key commits one nibble per press.
- After WIDTH/4 commits, the block presents the word with a valid/ready handshake to the register-file/memory write stage.
- Keeps a progress count and a sticky overrun flag for the display logic.

Parameters:
- WIDTH, 16, assembled word width; must be a multiple of 4 and at least 8.
- NIBBLES, WIDTH/4, derived localparam; number of commits per word.
- CNT_W, $clog2(NIBBLES+1), derived localparam; width of nibble_count.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- nibble_in  input  4  nibble from the switch converter; sampled only on an enter edge.
- enter  input  1  enter key, synchronized active-high level; the block detects its rising edge internally.
- clear  input  1  synchronous abort; discards any partial or held word.
- wr_ready  input  1  downstream ready to accept word_out.
- word_out  output  WIDTH  assembled word; MSB nibble is the one entered first.
- word_valid  output  1  word_out is complete and offered downstream.
- nibble_count  output  CNT_W  nibbles committed to the current word, 0..NIBBLES.
- overrun  output  1  sticky; set by an enter edge while a word is held.

Behaviour:
- Reset values (asynchronous):
  - state = COLLECT
  - shift register = 0, so word_out = 0
  - word_valid = 0, nibble_count = 0, overrun = 0
  - enter_q = 0
- Edge detect:
  - enter_q registers enter every cycle.
  - enter_edge = enter & ~enter_q, combinational.
  - If enter is high when reset releases, no edge is seen until enter falls and rises again.
  - A held key produces exactly one edge.
- State COLLECT:
  - word_valid = 0.
  - On enter_edge: shreg <= {shreg[WIDTH-5:0], nibble_in} and nibble_count increments.
  - If that commit makes nibble_count reach NIBBLES, go to HOLD.
  - word_valid rises the cycle after the edge that sampled the last nibble, i.e. one-cycle latency from the final edge.
- State HOLD:
  - word_valid = 1; word_out and nibble_count (= NIBBLES) stay stable.
  - Transfer occurs on any rising edge where word_valid & wr_ready. On transfer: shreg <= 0, nibble_count <= 0, state <= COLLECT.
  - word_valid drops the next cycle. A word is never accepted twice.
  - wr_ready is ignored in COLLECT; wr_ready tied high gives a one-cycle valid pulse.
  - An enter_edge in HOLD is not shifted in; it sets overrun = 1.
  - If enter_edge and transfer happen in the same cycle, the transfer wins and the nibble is dropped. overrun is still set.
- clear (priority below reset, above everything else):
  - Next edge: state = COLLECT, shreg = 0, nibble_count = 0, overrun = 0.
  - A word held in HOLD is discarded even if wr_ready is high in the same cycle; no transfer occurs.
  - An enter_edge in the same cycle is discarded.
  - enter_q still updates, so a held key does not re-fire after clear.
- Reset mid-word or mid-hold: all partial data is lost immediately, with no partial transfer.
- word_out always shows the live shift register, so partial entries are visible on the display during COLLECT.
- nibble_in is don't-care except on an enter_edge cycle.

Decomposition:
- Shared package (assembler_pkg):
  - NIBBLE_W = 4.
  - State typedef with members COLLECT and HOLD, 1-bit encoding.
  - Default WIDTH constant, shared with the register-file stage.
- Sub-module: rise_edge_detect (clk, reset, level_in, edge_out). Registered delay plus AND-NOT; reusable for other key inputs in the lab.
- Top contains the FSM, shift register, counter and overrun flag.

Test Plan (WIDTH=16):
- Four enter presses with nibble_in = 0001, 0000, 0001, 0001 and wr_ready = 0 -> nibble_count steps 1,2,3,4; word_out = 16'h1011; word_valid = 1 the cycle after the 4th edge, then held stable for 10 cycles.
- Presses with nibbles A, B, C, D, then wr_ready = 1 for one cycle -> exactly one transfer of 16'hABCD; next cycle word_valid = 0, word_out = 0, nibble_count = 0.
- enter held high for 20 cycles with nibble_in = 5 -> exactly one commit: nibble_count = 1, word_out = 16'h0005.
- Word held, 5th enter edge with nibble_in = F -> overrun = 1, word_out unchanged; after transfer overrun stays 1 until clear, then 0.
- Two nibbles entered (3, 7), then clear pulse coincident with an enter edge (nibble 9) -> word_out = 0, nibble_count = 0, overrun = 0; following presses 1,2,3,4 give 16'h1234.
- reset asserted asynchronously mid-cycle during HOLD with wr_ready = 1 -> word_valid and all outputs go to 0 immediately; no transfer is recorded by the bench's scoreboard.
